muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer with architectural HI/LO registers for the pipelined MIPS core.
- Replaces the single-cycle combinational multiply and divide paths, which would otherwise set the critical path.
- Accepts one operation at a time from EX and runs a restoring radix-2 divider or a latency-padded signed/unsigned multiplier.
- Raises busy so the hazard unit stalls HI/LO readers and further mul/div issues.

Parameters:
- MUL_LAT, 4, multiply latency in cycles from start to done; legal range 2..8.
- DIV_ITERS, 32, divider iteration count; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  issue request; sampled only when busy=0
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
- X  in  32  operand A (dividend / multiplicand / MT source)
- Y  in  32  operand B (divisor / multiplier)
- flush  in  1  abort in-flight operation (exception/branch flush)
- busy  out  1  operation in flight; new start ignored
- done  out  1  one-cycle pulse in the cycle HI/LO first show a mul/div result
- div_zero  out  1  qualifies done: the finished op was DIV/DIVU with Y=0
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, iteration counter=0. Reset mid-operation discards the operation.
- FSM states: IDLE, MUL_WAIT, DIV_ITER, DIV_FIX.
- Numbering: T is the cycle in which start=1 with busy=0. State changes at the edge ending each cycle.
- done and div_zero are registered and default to 0 every cycle.
- IDLE, op MULT/MULTU:
  - Latch the 64-bit product: signed for MULT, unsigned for MULTU.
  - Go to MUL_WAIT with counter = MUL_LAT-2.
  - The counter decrements each cycle. At the edge where it is 0, write {hi,lo} = product, set done=1, return to IDLE.
  - Result is visible in cycle T+MUL_LAT. busy=1 in T+1..T+MUL_LAT-1.
- IDLE, op DIV/DIVU:
  - Latch |X| and |Y|; for DIVU, latch raw X and Y.
  - Latch sign flags: quotient sign = X[31]^Y[31], remainder sign = X[31] (DIV only).
  - Latch zflag = (Y==0). Go to DIV_ITER.
- DIV_ITER: one restoring step per cycle:
  - Shift {rem,quot} left by 1, trial-subtract the divisor, restore if negative.
  - Runs DIV_ITERS cycles (T+1..T+32), then goes to DIV_FIX.
- DIV_FIX (cycle T+33):
  - Apply sign correction. Write lo=quotient, hi=remainder. Set done=1, div_zero=zflag. Return to IDLE.
  - Result is visible in cycle T+34. busy=1 in T+1..T+33.
- Divide by zero: lo=32'hFFFFFFFF and hi=X (raw, unsigned and signed alike). Latency is unchanged at 34.
- Signed overflow 0x80000000 / -1 (DIV): lo=32'h80000000, hi=0. No trap.
- MTHI/MTLO in IDLE: hi (or lo) = X at the edge ending T. No busy, no done.
- op 6/7 with start: ignored.
- start while busy=1: ignored. The issuer must stall on busy.
- busy is high in every non-IDLE state.
- flush: at the next edge, any non-IDLE state returns to IDLE. hi/lo are untouched and done stays 0.
  - flush and start in the same IDLE cycle: flush wins and start is dropped.
  - flush in the same cycle that would write hi/lo (last MUL_WAIT cycle, or DIV_FIX): flush wins and there is no write.
- hi/lo are readable every cycle. While busy, they hold their previous values.

Decomposition:
- Shared package (muldiv_pkg): op encodings (OP_MULT…OP_MTLO), FSM state encoding, DIV_ITERS constant.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quot, divisor (32 each).
  - Outputs: next rem, next quot.
- Sign fix-up, MUL_WAIT delay and FSM stay in the top level.

Test Plan:
- MULT X=32'hFFFFFFFE (-2), Y=3 -> done at T+4, {hi,lo}=64'hFFFFFFFF_FFFFFFFA; MULTU same operands -> hi=32'h00000002, lo=32'hFFFFFFFA.
- DIV X=-7 (32'hFFFFFFF9), Y=2 -> done at T+34, lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU X=100, Y=7 -> lo=14, hi=2.
- DIVU X=123, Y=0 -> done and div_zero at T+34, lo=32'hFFFFFFFF, hi=123; DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- Start DIV, then assert flush at T+10 -> busy=0 from T+11, no done, hi/lo keep prior values (preload via MTHI=32'hAAAA0000, MTLO=32'h0000BBBB).
- start MULT at T+5 of a running DIV -> ignored; only the DIV result appears at T+34. MTLO X=5 in idle -> lo=5 next cycle, done stays 0.
- rst_n=0 during DIV_ITER -> next cycle busy=0, hi=lo=0. Back-to-back: new start in T+34 (done cycle) is accepted.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DivIters = 32;
  localparam int unsigned CntW     = $clog2(DivIters);

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMulWait,
    StDivIter,
    StDivFix
  } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between EX and the mul/div sequencer.
interface muldiv_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, x, y, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, x, y, flush,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq_div_step.sv
// One restoring radix-2 division step on a {rem, quot} pair.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quot_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quot_o
);

  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    shifted = {rem_i, quot_i[31]};
    trial   = shifted - {1'b0, divisor_i};
    // A borrow out of bit 32 means the divisor did not fit: keep the shifted remainder.
    if (trial[32]) begin
      rem_o  = shifted[31:0];
      quot_o = {quot_i[30:0], 1'b0};
    end else begin
      rem_o  = trial[31:0];
      quot_o = {quot_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned MulLat = 4
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       prod_q, prod_d;
  logic [31:0]       rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, zflag_q, zflag_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d, dz_q, dz_d;
  logic [31:0]       rem_nx, quot_nx;
  logic              is_signed;

  div_step u_div_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_nx),
    .quot_o    (quot_nx)
  );

  assign is_signed = (bus.op == OpDiv);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zflag_d = zflag_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            OpMult: begin
              prod_d  = $signed({{32{bus.x[31]}}, bus.x}) * $signed({{32{bus.y[31]}}, bus.y});
              cnt_d   = CntW'(MulLat - 2);
              state_d = StMulWait;
            end
            OpMultu: begin
              prod_d  = {32'd0, bus.x} * {32'd0, bus.y};
              cnt_d   = CntW'(MulLat - 2);
              state_d = StMulWait;
            end
            OpDiv, OpDivu: begin
              quot_d  = (is_signed && bus.x[31]) ? -bus.x : bus.x;
              dvsr_d  = (is_signed && bus.y[31]) ? -bus.y : bus.y;
              rem_d   = '0;
              qneg_d  = is_signed && (bus.x[31] ^ bus.y[31]);
              rneg_d  = is_signed && bus.x[31];
              zflag_d = (bus.y == 32'd0);
              cnt_d   = CntW'(DivIters - 1);
              state_d = StDivIter;
            end
            OpMthi: hi_d = bus.x;
            OpMtlo: lo_d = bus.x;
            default: ;
          endcase
        end
      end
      StMulWait: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = prod_q;
          done_d       = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDivIter: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          rem_d  = rem_nx;
          quot_d = quot_nx;
          if (cnt_q == '0) state_d = StDivFix;
          else cnt_d = cnt_q - CntW'(1);
        end
      end
      StDivFix: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          // Divide by zero leaves quot all ones and rem = |X|; the remainder fix restores raw X.
          lo_d    = (qneg_q && !zflag_q) ? -quot_q : quot_q;
          hi_d    = rneg_q ? -rem_q : rem_q;
          done_d  = 1'b1;
          dz_d    = zflag_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zflag_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zflag_q <= zflag_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

  localparam int MulLat = 4;
  localparam int DivLat = 34;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  muldiv_seq_if m ();

  muldiv_seq #(
    .MulLat (MulLat)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: results straight from integer arithmetic plus the documented special cases.
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic ez, output int elat);
    longint          sx, sy, sp;
    longint unsigned ux, uy, up;
    int              ix, iy;
    ez = 1'b0;
    eh = '0;
    el = '0;
    elat = DivLat;
    case (op)
      3'd0: begin
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        sp = sx * sy;
        {eh, el} = sp;
        elat = MulLat;
      end
      3'd1: begin
        ux = {32'd0, x};
        uy = {32'd0, y};
        up = ux * uy;
        {eh, el} = up;
        elat = MulLat;
      end
      default: begin
        if (y == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = x;
          ez = 1'b1;
        end else if (op == 3'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'd0;
        end else if (op == 3'd2) begin
          ix = x;
          iy = y;
          el = ix / iy;
          eh = ix % iy;
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    logic [31:0] eh, el;
    logic        ez;
    int          elat;
    int          lat;
    model(op, x, y, eh, el, ez, elat);
    m.start = 1'b1;
    m.op    = op;
    m.x     = x;
    m.y     = y;
    lat     = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      m.start = 1'b0;
      if (k == 1) begin
        n_vec++;
        if (m.busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy_t1: got %b want 1", tag, m.busy);
        end
      end
      if (m.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_vec++;
    if (lat != elat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, elat);
    end
    n_vec++;
    if (m.hi !== eh) begin
      n_err++;
      $display("FAIL %s hi: got %h want %h (op=%0d x=%h y=%h)", tag, m.hi, eh, op, x, y);
    end
    n_vec++;
    if (m.lo !== el) begin
      n_err++;
      $display("FAIL %s lo: got %h want %h (op=%0d x=%h y=%h)", tag, m.lo, el, op, x, y);
    end
    n_vec++;
    if (m.div_zero !== ez) begin
      n_err++;
      $display("FAIL %s div_zero: got %b want %b", tag, m.div_zero, ez);
    end
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] ehi, input logic [31:0] elo);
    m.start = 1'b1;
    m.op    = op;
    m.x     = x;
    m.y     = 32'd0;
    step();
    m.start = 1'b0;
    n_vec++;
    if (m.hi !== ehi || m.lo !== elo || m.done !== 1'b0 || m.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mt: got hi=%h lo=%h done=%b busy=%b want hi=%h lo=%h done=0 busy=0",
               m.hi, m.lo, m.done, m.busy, ehi, elo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    n_vec++;
    if (m.busy !== 1'b0 || m.done !== 1'b0 || m.div_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got busy=%b done=%b dz=%b want 0 0 0",
               m.busy, m.done, m.div_zero);
    end
    n_vec++;
    if (m.hi !== 32'd0 || m.lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_hilo: got hi=%h lo=%h want 0 0", m.hi, m.lo);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, "multu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(3'd3, 32'd100, 32'd7, "divu");
    run_op(3'd3, 32'd123, 32'd0, "divu_zero");
    run_op(3'd2, 32'h8000_0005, 32'd0, "div_zero_neg");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(3, 0));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(7, 0))
        0: y = 32'd0;
        1: y = 32'($urandom_range(9, 1));
        2: y = -32'($urandom_range(9, 1));
        default: ;
      endcase
      run_op(op, x, y, "random");
    end
  endtask

  task automatic test_mt();
    do_mt(3'd4, 32'hAAAA_0000, 32'hAAAA_0000, m.lo);
    do_mt(3'd5, 32'd5, 32'hAAAA_0000, 32'd5);
    // Opcodes 6/7 must leave HI/LO alone.
    do_mt(3'd6, 32'h1234_5678, 32'hAAAA_0000, 32'd5);
  endtask

  task automatic test_flush();
    bit seen_done;
    do_mt(3'd4, 32'hAAAA_0000, 32'hAAAA_0000, m.lo);
    do_mt(3'd5, 32'h0000_BBBB, 32'hAAAA_0000, 32'h0000_BBBB);
    m.start = 1'b1;
    m.op    = 3'd2;
    m.x     = 32'd1000;
    m.y     = 32'd3;
    seen_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      m.start = 1'b0;
      if (k == 10) m.flush = 1'b1;
      if (k == 11) begin
        m.flush = 1'b0;
        n_vec++;
        if (m.busy !== 1'b0) begin
          n_err++;
          $display("FAIL flush_busy: got %b want 0", m.busy);
        end
      end
      if (m.done === 1'b1) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done || m.hi !== 32'hAAAA_0000 || m.lo !== 32'h0000_BBBB) begin
      n_err++;
      $display("FAIL flush_hold: got done_seen=%b hi=%h lo=%h want 0 aaaa0000 0000bbbb",
               seen_done, m.hi, m.lo);
    end
    // Flush and start together in idle: the start is dropped.
    m.start = 1'b1;
    m.flush = 1'b1;
    m.op    = 3'd0;
    m.x     = 32'd7;
    m.y     = 32'd9;
    seen_done = 1'b0;
    step();
    m.start = 1'b0;
    m.flush = 1'b0;
    n_vec++;
    if (m.busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start_busy: got %b want 0", m.busy);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      if (m.done === 1'b1) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done || m.lo !== 32'h0000_BBBB) begin
      n_err++;
      $display("FAIL flush_start_drop: got done_seen=%b lo=%h want 0 0000bbbb", seen_done, m.lo);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    m.start = 1'b1;
    m.op    = 3'd3;
    m.x     = 32'd100;
    m.y     = 32'd7;
    lat     = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      m.start = 1'b0;
      if (k == 5) begin
        m.start = 1'b1;
        m.op    = 3'd0;
        m.x     = 32'd3;
        m.y     = 32'd5;
      end
      if (m.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_vec++;
    if (lat != DivLat || m.lo !== 32'd14 || m.hi !== 32'd2) begin
      n_err++;
      $display("FAIL ignore_busy: got lat=%0d hi=%h lo=%h want %0d 2 14", lat, m.hi, m.lo, DivLat);
    end
    step();
    n_vec++;
    if (m.done !== 1'b0 || m.busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_busy_after: got done=%b busy=%b want 0 0", m.done, m.busy);
    end
  endtask

  task automatic test_reset_mid();
    do_mt(3'd4, 32'h1234_0000, 32'h1234_0000, m.lo);
    m.start = 1'b1;
    m.op    = 3'd2;
    m.x     = 32'd77;
    m.y     = 32'd5;
    for (int k = 1; k <= 5; k++) begin
      step();
      m.start = 1'b0;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_vec++;
    if (m.busy !== 1'b0 || m.hi !== 32'd0 || m.lo !== 32'd0 || m.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h done=%b want 0 0 0 0",
               m.busy, m.hi, m.lo, m.done);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd0, 32'd12345, 32'hFFFF_FF00, "b2b_mult");
    run_op(3'd3, 32'hDEAD_BEEF, 32'd1000, "b2b_divu");
    run_op(3'd2, 32'h8765_4321, 32'd17, "b2b_div");
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    m.start = 1'b0;
    m.op    = 3'd7;
    m.x     = '0;
    m.y     = '0;
    m.flush = 1'b0;
    test_reset();
    test_directed();
    test_mt();
    test_flush();
    test_ignore_busy();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
